// File: rtl/page_sub_pkg.sv
// Shared types and helpers for the N-way page subdivide wrapper and its FIFOs.
`default_nettype none

package page_sub_pkg;

  localparam int PKT_W_DEFAULT = 49;
  // Helpers take a zero-extended packet so they work for any PKT_W up to this width.
  localparam int PKT_MAX_W     = 512;

  function automatic logic valid_bit(input logic [PKT_MAX_W-1:0] pkt, input int unsigned w);
    return pkt[w-1];
  endfunction

  function automatic logic [7:0] page_sel(input logic [PKT_MAX_W-1:0] pkt,
                                          input int unsigned lsb,
                                          input int unsigned w);
    logic [PKT_MAX_W-1:0] shifted;
    logic [7:0]           mask;
    shifted = pkt >> lsb;
    mask    = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      if (b < w) mask[b] = 1'b1;
    end
    return shifted[7:0] & mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/page_leaf_fifo.sv
// Single-clock FIFO with an occupancy counter; full/empty are derived from the count.
`default_nettype none

module page_leaf_fifo #(
  parameter int WIDTH = 49,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int           AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]  CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage needs no reset: the count alone decides what is readable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/page_nway_subdivide.sv
// One BFT leaf fanned out to NUM_PAGES child pages: registered demux down, round-robin merge up.
// Optional per-child/up packet counters when PAGE_NWAY_SUBDIVIDE_STATS_EN is defined.
`default_nettype none

module page_nway_subdivide
  import page_sub_pkg::*;
#(
  parameter int NUM_PAGES  = 4,
  parameter int PKT_W      = PKT_W_DEFAULT,
  parameter int SEL_LSB    = 44,
  parameter int SEL_W      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [PKT_W-1:0]           din_leaf_bft2interface,
  output logic [PKT_W-1:0]           dout_leaf_interface2bft,
  input  logic                       resend,
  input  logic                       ap_start,
  output logic [NUM_PAGES*PKT_W-1:0] din_page,
  input  logic [NUM_PAGES*PKT_W-1:0] dout_page,
  output logic [NUM_PAGES-1:0]       resend_page,
  output logic [NUM_PAGES-1:0]       ap_start_page,
  output logic [NUM_PAGES-1:0]       overflow_sticky,
  output logic                       misroute_sticky
`ifdef PAGE_NWAY_SUBDIVIDE_STATS_EN
  ,
  output logic [NUM_PAGES*16-1:0]    pkt_cnt_down,
  output logic [15:0]                pkt_cnt_up
`endif
);

  localparam int PW = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;

  logic [PKT_MAX_W-1:0]       din_ext;
  logic                       din_valid;
  logic [7:0]                 din_sel;
  logic                       misroute_hit;
  logic [NUM_PAGES*PKT_W-1:0] din_page_next;

  logic [NUM_PAGES-1:0]       push;
  logic [NUM_PAGES-1:0]       pop;
  logic [NUM_PAGES-1:0]       full;
  logic [NUM_PAGES-1:0]       empty;
  logic [NUM_PAGES-1:0]       ovf_pulse;
  logic [PKT_W-1:0]           fifo_dout [NUM_PAGES];

  logic [PW-1:0]              ptr;
  logic [PW-1:0]              ptr_next;
  logic                       grant_valid;
  logic [PW-1:0]              grant_idx;
  int unsigned                rr_idx;

  (* dont_touch = "true" *) logic [PKT_W-1:0]           dout_q;
  (* dont_touch = "true" *) logic [NUM_PAGES*PKT_W-1:0] din_page_q;
  (* dont_touch = "true" *) logic [NUM_PAGES-1:0]       resend_q;
  (* dont_touch = "true" *) logic [NUM_PAGES-1:0]       ap_start_q;
  (* dont_touch = "true" *) logic [NUM_PAGES-1:0]       overflow_q;
  (* dont_touch = "true" *) logic                       misroute_q;

  always_comb begin
    din_ext            = '0;
    din_ext[PKT_W-1:0] = din_leaf_bft2interface;
    din_valid          = valid_bit(din_ext, PKT_W);
    din_sel            = page_sel(din_ext, SEL_LSB, SEL_W);
  end

  assign misroute_hit = din_valid && (din_sel >= 8'(NUM_PAGES));

  always_comb begin
    din_page_next = '0;
    for (int i = 0; i < NUM_PAGES; i++) begin
      if (din_valid && (din_sel == 8'(i))) din_page_next[i*PKT_W +: PKT_W] = din_leaf_bft2interface;
    end
  end

  for (genvar i = 0; i < NUM_PAGES; i++) begin : g_child
    logic [PKT_W-1:0] up_pkt;
    logic             up_valid;

    assign up_pkt       = dout_page[i*PKT_W +: PKT_W];
    assign up_valid     = up_pkt[PKT_W-1];
    // Fullness is judged before this cycle's pop, so a full FIFO always drops.
    assign push[i]      = up_valid && !full[i];
    assign ovf_pulse[i] = up_valid && full[i];

    page_leaf_fifo #(
      .WIDTH (PKT_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push[i]),
      .pop     (pop[i]),
      .din     (up_pkt),
      .dout    (fifo_dout[i]),
      .full    (full[i]),
      .empty   (empty[i])
    );
  end

  // Round-robin: first non-empty FIFO at or after the pointer wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    rr_idx      = 0;
    for (int unsigned k = 0; k < NUM_PAGES; k++) begin
      rr_idx = 32'(ptr) + k;
      if (rr_idx >= NUM_PAGES) rr_idx = rr_idx - NUM_PAGES;
      if (!grant_valid && !empty[rr_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = PW'(rr_idx);
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_PAGES; i++) begin
      pop[i] = grant_valid && (grant_idx == PW'(i));
    end
  end

  assign ptr_next = (grant_idx == PW'(NUM_PAGES - 1)) ? '0 : grant_idx + PW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_q     <= '0;
      din_page_q <= '0;
      resend_q   <= '0;
      ap_start_q <= '0;
      overflow_q <= '0;
      misroute_q <= 1'b0;
      ptr        <= '0;
    end else begin
      dout_q     <= grant_valid ? fifo_dout[grant_idx] : '0;
      din_page_q <= din_page_next;
      resend_q   <= {NUM_PAGES{resend}} | ovf_pulse;
      ap_start_q <= {NUM_PAGES{ap_start}};
      overflow_q <= overflow_q | ovf_pulse;
      misroute_q <= misroute_q | misroute_hit;
      if (grant_valid) ptr <= ptr_next;
    end
  end

  assign dout_leaf_interface2bft = dout_q;
  assign din_page                = din_page_q;
  assign resend_page             = resend_q;
  assign ap_start_page           = ap_start_q;
  assign overflow_sticky         = overflow_q;
  assign misroute_sticky         = misroute_q;

`ifdef PAGE_NWAY_SUBDIVIDE_STATS_EN
  logic [NUM_PAGES*16-1:0] cnt_down_q;
  logic [15:0]             cnt_up_q;

  // Every granted word is valid, since only valid packets are ever pushed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_down_q <= '0;
      cnt_up_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_PAGES; i++) begin
        if (din_page_next[i*PKT_W + PKT_W - 1]) cnt_down_q[i*16 +: 16] <= cnt_down_q[i*16 +: 16] + 16'd1;
      end
      if (grant_valid) cnt_up_q <= cnt_up_q + 16'd1;
    end
  end

  assign pkt_cnt_down = cnt_down_q;
  assign pkt_cnt_up   = cnt_up_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_page_nway_subdivide.sv
// Randomized bench for page_nway_subdivide against a queue-based reference model.
`default_nettype none

module tb_page_nway_subdivide;

  localparam int NP  = 4;
  localparam int PKW = 49;
  localparam int SL  = 44;
  localparam int SW  = 3;
  localparam int FD  = 4;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic [PKW-1:0]      din_leaf = '0;
  logic [PKW-1:0]      dout_leaf;
  logic                resend = 1'b0;
  logic                ap_start = 1'b0;
  logic [NP*PKW-1:0]   din_page;
  logic [NP*PKW-1:0]   dout_page = '0;
  logic [NP-1:0]       resend_page;
  logic [NP-1:0]       ap_start_page;
  logic [NP-1:0]       overflow_sticky;
  logic                misroute_sticky;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: one queue per child plus the expected registered outputs.
  logic [PKW-1:0]    mq [NP][$];
  int                mptr = 0;
  logic [PKW-1:0]    exp_dout = '0;
  logic [NP*PKW-1:0] exp_din_page = '0;
  logic [NP-1:0]     exp_resend = '0;
  logic [NP-1:0]     exp_ap = '0;
  logic [NP-1:0]     exp_ovf = '0;
  logic              exp_mis = 1'b0;

  page_nway_subdivide #(
    .NUM_PAGES  (NP),
    .PKT_W      (PKW),
    .SEL_LSB    (SL),
    .SEL_W      (SW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .din_leaf_bft2interface  (din_leaf),
    .dout_leaf_interface2bft (dout_leaf),
    .resend                  (resend),
    .ap_start                (ap_start),
    .din_page                (din_page),
    .dout_page               (dout_page),
    .resend_page             (resend_page),
    .ap_start_page           (ap_start_page),
    .overflow_sticky         (overflow_sticky),
    .misroute_sticky         (misroute_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [PKW-1:0] mkpkt(input bit v, input int sel);
    logic [PKW-1:0] p;
    p = PKW'({$urandom, $urandom});
    p[PKW-1]  = v;
    p[SL+:SW] = SW'(sel);
    return p;
  endfunction

  task automatic check_outputs();
    check("dout",     256'(dout_leaf),       256'(exp_dout));
    check("din_page", 256'(din_page),        256'(exp_din_page));
    check("resend",   256'(resend_page),     256'(exp_resend));
    check("ap_start", 256'(ap_start_page),   256'(exp_ap));
    check("overflow", 256'(overflow_sticky), 256'(exp_ovf));
    check("misroute", 256'(misroute_sticky), 256'(exp_mis));
  endtask

  task automatic model_update(input logic [PKW-1:0] d, input logic rs, input logic ap,
                              input logic [NP*PKW-1:0] up);
    int         sel;
    bit         found;
    bit         was_full [NP];
    logic [NP-1:0]  ovf;
    logic [PKW-1:0] pkt;
    exp_din_page = '0;
    sel = int'(d[SL+:SW]);
    if (d[PKW-1]) begin
      if (sel < NP) exp_din_page[sel*PKW +: PKW] = d;
      else exp_mis = 1'b1;
    end
    for (int i = 0; i < NP; i++) was_full[i] = (mq[i].size() >= FD);
    exp_dout = '0;
    found = 0;
    for (int k = 0; k < NP; k++) begin
      int idx;
      idx = (mptr + k) % NP;
      if (!found && mq[idx].size() > 0) begin
        exp_dout = mq[idx].pop_front();
        mptr = (idx + 1) % NP;
        found = 1;
      end
    end
    ovf = '0;
    for (int i = 0; i < NP; i++) begin
      pkt = up[i*PKW +: PKW];
      if (pkt[PKW-1]) begin
        if (was_full[i]) ovf[i] = 1'b1;
        else mq[i].push_back(pkt);
      end
    end
    exp_ovf    = exp_ovf | ovf;
    exp_resend = {NP{rs}} | ovf;
    exp_ap     = {NP{ap}};
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) mq[i].delete();
    mptr = 0;
    exp_dout = '0; exp_din_page = '0; exp_resend = '0;
    exp_ap = '0; exp_ovf = '0; exp_mis = 1'b0;
  endtask

  task automatic step(input logic [PKW-1:0] d, input logic rs, input logic ap,
                      input logic [NP*PKW-1:0] up);
    @(negedge clk);
    check_outputs();
    din_leaf = d; resend = rs; ap_start = ap; dout_page = up;
    model_update(d, rs, ap, up);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0, '0);
  endtask

  function automatic logic [NP*PKW-1:0] gen_up(input int pct);
    logic [NP*PKW-1:0] u;
    for (int i = 0; i < NP; i++) begin
      u[i*PKW +: PKW] = mkpkt($urandom_range(99) < pct, $urandom_range(7));
    end
    return u;
  endfunction

  initial begin
    logic [NP*PKW-1:0] up;
    logic [PKW-1:0]    d;
    int                pct;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Downstream to page 2, then an out-of-range index.
    step(mkpkt(1, 2), 1'b0, 1'b0, '0);
    idle(2);
    step(mkpkt(1, 5), 1'b0, 1'b0, '0);
    idle(2);

    // Children 0, 1, 3 push together.
    up = '0;
    up[0*PKW +: PKW] = mkpkt(1, 0);
    up[1*PKW +: PKW] = mkpkt(1, 0);
    up[3*PKW +: PKW] = mkpkt(1, 0);
    step('0, 1'b0, 1'b0, up);
    idle(6);

    // Children 0 and 1 stream back-to-back until child 1 overflows.
    for (int c = 0; c < 10; c++) begin
      up = '0;
      up[0*PKW +: PKW] = mkpkt(1, 0);
      up[1*PKW +: PKW] = mkpkt(1, 1);
      step('0, 1'b0, 1'b0, up);
    end
    idle(24);

    // Control broadcast.
    step('0, 1'b1, 1'b1, '0);
    idle(3);

    // Fill FIFOs, then reset asynchronously mid-stream.
    for (int c = 0; c < 3; c++) step(mkpkt(1, c), 1'b0, 1'b0, gen_up(100));
    @(negedge clk);
    check_outputs();
    din_leaf = '0; resend = 1'b0; ap_start = 1'b0; dout_page = '0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle(4);

    // Randomized traffic with varying upstream load.
    for (int c = 0; c < 800; c++) begin
      pct = (c < 200) ? 20 : (c < 500) ? 60 : 95;
      d = mkpkt($urandom_range(1), ($urandom_range(9) == 0) ? $urandom_range(7, 4) : $urandom_range(3));
      step(d, $urandom_range(7) == 0, $urandom_range(7) == 0, gen_up(pct));
    end
    idle(30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
